id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  Clocked, parametrised ID->EX pipeline register with a valid/ready handshake and a 2-entry skid buffer.
//  Carries the WB/M/EX control fields, npc, both register-read values, the sign-extended immediate, and rt/rd.
//  Adds stall by backpressure, synchronous flush, and bubble insertion, none of which the combinational latch had.
//  Sits between the decode stage (register file, control unit) and the execute stage (ALU, dest-reg mux).
// PARAMETERS
//  DW        32  width of npc, rdata1, rdata2 and sext
//  RW        5   register-specifier width (rt, rd)
//  WB_W      2   WB control width
//  M_W       3   MEM control width
//  EX_W      4   EX control width
//  ZERO_BUB  1   1: force the control outputs to 0 while out_valid=0. 0: the control outputs hold their last value.
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     asynchronous reset, active low
//  flush      in   1     synchronous squash of every held entry (branch/jump taken)
//  in_valid   in   1     decode presents a valid bundle
//  in_ready   out  1     the stage can accept a bundle this cycle
//  in_wb/in_m/in_ex  in  WB_W/M_W/EX_W  control fields
//  in_npc, in_rdata1, in_rdata2, in_sext  in  DW  datapath fields
//  in_rt, in_rd  in  RW   instr[20:16] and instr[15:11]
//  out_valid  out  1     execute sees a valid bundle
//  out_ready  in   1     execute consumes the bundle (0 = stall)
//  out_*      out  -     registered copies of every in_* field, at the same widths
//  occ        out  2     occupancy, 0..2
// BEHAVIOUR
//  - Reset (async, rst_n=0): every out_* field = 0, out_valid=0, in_ready=1, occ=0, state=EMPTY.
//  - Accept = in_valid & in_ready. Consume = out_valid & out_ready. All updates occur on the rising edge of clk.
//  - States:
//    - EMPTY (occ 0): on accept -> ONE. The main register loads the bundle.
//    - ONE (occ 1):
//      - accept & consume -> ONE. The main register reloads.
//      - accept & !consume -> FULL. The bundle goes to the skid register.
//      - consume only -> EMPTY.
//    - FULL (occ 2): in_ready=0. On consume -> ONE, and the skid entry moves into the main register.
//  - in_ready is a registered signal equal to (state != FULL). It has no combinational path from out_ready.
//  - Latency: a bundle accepted into EMPTY appears on out_* with out_valid=1 in the next cycle.
//  - Ordering is strictly FIFO. No bundle is dropped or duplicated, except by flush.
//  - Flush:
//    - The next state is EMPTY, regardless of accept or consume in the same cycle.
//    - A bundle presented in the flush cycle is discarded, even if it was accepted.
//    - out_valid=0 and in_ready=1 in the following cycle.
//    - Datapath outputs hold their values. Control outputs go to 0 if ZERO_BUB=1.
//  - Bubble: while out_valid=0 and ZERO_BUB=1, out_wb, out_m and out_ex read 0, so no spurious register write or memory access occurs.
//  - Reset asserted mid-operation clears all state immediately. Outputs return to the reset values without waiting for a clock edge.
//  - No arithmetic is performed. Every field passes through bit-exact at its declared width.
// STRUCTURE
//  - Shared package pipe_pkg:
//    - localparams for the default widths DW, RW, WB_W, M_W and EX_W
//    - typedef id_ex_bundle_t, a packed struct of all the fields
//    - typedef enum skid_state_t {EMPTY, ONE, FULL}
//  - One sub-module, pipe_bundle_reg: a width-parametrised enable register with async active-low clear.
//    It is instantiated twice, once for the main register and once for the skid register.
//  - The FSM, the handshake logic and the bubble masking live in id_ex_stage_reg.
// TESTING
//  1. Reset: hold rst_n=0 for 3 cycles with random inputs -> out_valid=0, in_ready=1, occ=0, all out_* fields=0.
//  2. Streaming: out_ready=1; drive npc=0x04,0x08,0x0C on consecutive cycles.
//     -> out_npc shows 0x04,0x08,0x0C one cycle later each, and occ stays at 1.
//  3. Stall: accept A (rdata1=0xAAAA), then B, with out_ready=0.
//     -> occ=2 and in_ready=0. Hold 3 cycles: out_rdata1 stays 0xAAAA.
//     -> On release: A, then B, then out_valid=0.
//  4. Flush with the FULL state plus an input in the same cycle.
//     -> The next cycle: out_valid=0, occ=0, in_ready=1, out_wb=0, and neither entry nor the input ever appears.
//  5. Bubble masking: ZERO_BUB=1, accept wb=2'b11 then starve the input -> out_wb=0 while out_valid=0.
//     Repeat with ZERO_BUB=0 -> out_wb stays 2'b11.
//  6. Async reset: pull rst_n low between clock edges while in FULL.
//     -> Outputs clear before the next edge. After release, normal accept resumes on the first valid input.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the ID->EX pipeline register: default field widths,
// the packed bundle carried from decode to execute, and the skid FSM states.
package pipe_pkg;

  localparam int DEF_DW   = 32;
  localparam int DEF_RW   = 5;
  localparam int DEF_WB_W = 2;
  localparam int DEF_M_W  = 3;
  localparam int DEF_EX_W = 4;

  // One decode->execute bundle at the default widths, control fields first.
  typedef struct packed {
    logic [DEF_WB_W-1:0] wb;
    logic [DEF_M_W-1:0]  m;
    logic [DEF_EX_W-1:0] ex;
    logic [DEF_DW-1:0]   npc;
    logic [DEF_DW-1:0]   rdata1;
    logic [DEF_DW-1:0]   rdata2;
    logic [DEF_DW-1:0]   sext;
    logic [DEF_RW-1:0]   rt;
    logic [DEF_RW-1:0]   rd;
  } id_ex_bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Number of held bundles for a given FSM state.
  function automatic logic [1:0] occ_of(skid_state_t s);
    case (s)
      EMPTY:   occ_of = 2'd0;
      ONE:     occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_bundle_reg.sv
// Width-parametrised enable register with asynchronous active-low clear.
// Used for both the main (output) register and the skid register.
module pipe_bundle_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load on enable, otherwise hold; clear immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with valid/ready handshake and a 2-entry skid
// buffer. The main register always holds the oldest bundle (what execute
// sees); the skid register catches one extra bundle accepted while execute
// stalls, so in_ready can be registered with no path from out_ready.
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int RW       = DEF_RW,
  parameter int WB_W     = DEF_WB_W,
  parameter int M_W      = DEF_M_W,
  parameter int EX_W     = DEF_EX_W,
  parameter bit ZERO_BUB = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WB_W-1:0] in_wb,
  input  logic [M_W-1:0]  in_m,
  input  logic [EX_W-1:0] in_ex,
  input  logic [DW-1:0]   in_npc,
  input  logic [DW-1:0]   in_rdata1,
  input  logic [DW-1:0]   in_rdata2,
  input  logic [DW-1:0]   in_sext,
  input  logic [RW-1:0]   in_rt,
  input  logic [RW-1:0]   in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WB_W-1:0] out_wb,
  output logic [M_W-1:0]  out_m,
  output logic [EX_W-1:0] out_ex,
  output logic [DW-1:0]   out_npc,
  output logic [DW-1:0]   out_rdata1,
  output logic [DW-1:0]   out_rdata2,
  output logic [DW-1:0]   out_sext,
  output logic [RW-1:0]   out_rt,
  output logic [RW-1:0]   out_rd,
  output logic [1:0]      occ
);

  localparam int BW = WB_W + M_W + EX_W + 4*DW + 2*RW;

  skid_state_t   state, state_nxt;
  logic          accept, consume;
  logic          main_en, skid_en, main_from_skid;
  logic [BW-1:0] in_flat, main_d, main_q, skid_q;

  logic [WB_W-1:0] main_wb;
  logic [M_W-1:0]  main_m;
  logic [EX_W-1:0] main_ex;

  assign accept  = in_valid  & in_ready;
  assign consume = out_valid & out_ready;

  assign in_flat = {in_wb, in_m, in_ex, in_npc, in_rdata1, in_rdata2,
                    in_sext, in_rt, in_rd};

  // Draining FULL refills the main register from skid; otherwise from input.
  assign main_d = main_from_skid ? skid_q : in_flat;

  // Next state and register enables; flush wins over any accept/consume and
  // blocks all loads so the datapath outputs keep their last values.
  always_comb begin
    state_nxt      = state;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          main_en   = 1'b1;
        end
      end
      ONE: begin
        if (accept && consume) begin
          main_en = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          skid_en   = 1'b1;
        end else if (consume) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          state_nxt      = ONE;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
      main_en   = 1'b0;
      skid_en   = 1'b0;
    end
  end

  // State plus registered handshake/occupancy outputs derived from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occ       <= 2'd0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != FULL);
      out_valid <= (state_nxt != EMPTY);
      occ       <= occ_of(state_nxt);
    end
  end

  pipe_bundle_reg #(.W(BW)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_bundle_reg #(.W(BW)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (in_flat),
    .q     (skid_q)
  );

  assign {main_wb, main_m, main_ex, out_npc, out_rdata1, out_rdata2,
          out_sext, out_rt, out_rd} = main_q;

  // Bubbles carry zero control so execute never writes a register or
  // touches memory for an invalid slot.
  generate
    if (ZERO_BUB) begin : g_zero_bub
      assign out_wb = out_valid ? main_wb : '0;
      assign out_m  = out_valid ? main_m  : '0;
      assign out_ex = out_valid ? main_ex : '0;
    end else begin : g_hold_ctl
      assign out_wb = main_wb;
      assign out_m  = main_m;
      assign out_ex = main_ex;
    end
  endgenerate

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: two instances on shared inputs (ZERO_BUB=1 and
// ZERO_BUB=0), a FIFO scoreboard of accepted bundles, per-cycle comparison.
module tb_id_ex_stage_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  id_ex_bundle_t ib;

  // ZERO_BUB=1 instance outputs
  logic        in_ready_z, out_valid_z;
  logic [1:0]  occ_z, out_wb_z;
  logic [2:0]  out_m_z;
  logic [3:0]  out_ex_z;
  logic [31:0] out_npc_z, out_rdata1_z, out_rdata2_z, out_sext_z;
  logic [4:0]  out_rt_z, out_rd_z;
  // ZERO_BUB=0 instance outputs
  logic        in_ready_h, out_valid_h;
  logic [1:0]  occ_h, out_wb_h;
  logic [2:0]  out_m_h;
  logic [3:0]  out_ex_h;
  logic [31:0] out_npc_h, out_rdata1_h, out_rdata2_h, out_sext_h;
  logic [4:0]  out_rt_h, out_rd_h;

  id_ex_bundle_t obz, obh;
  assign obz = {out_wb_z, out_m_z, out_ex_z, out_npc_z, out_rdata1_z,
                out_rdata2_z, out_sext_z, out_rt_z, out_rd_z};
  assign obh = {out_wb_h, out_m_h, out_ex_h, out_npc_h, out_rdata1_h,
                out_rdata2_h, out_sext_h, out_rt_h, out_rd_h};

  id_ex_stage_reg #(.ZERO_BUB(1'b1)) dut_z (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_z),
    .in_wb(ib.wb), .in_m(ib.m), .in_ex(ib.ex), .in_npc(ib.npc),
    .in_rdata1(ib.rdata1), .in_rdata2(ib.rdata2), .in_sext(ib.sext),
    .in_rt(ib.rt), .in_rd(ib.rd),
    .out_valid(out_valid_z), .out_ready(out_ready),
    .out_wb(out_wb_z), .out_m(out_m_z), .out_ex(out_ex_z), .out_npc(out_npc_z),
    .out_rdata1(out_rdata1_z), .out_rdata2(out_rdata2_z), .out_sext(out_sext_z),
    .out_rt(out_rt_z), .out_rd(out_rd_z), .occ(occ_z)
  );

  id_ex_stage_reg #(.ZERO_BUB(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_h),
    .in_wb(ib.wb), .in_m(ib.m), .in_ex(ib.ex), .in_npc(ib.npc),
    .in_rdata1(ib.rdata1), .in_rdata2(ib.rdata2), .in_sext(ib.sext),
    .in_rt(ib.rt), .in_rd(ib.rd),
    .out_valid(out_valid_h), .out_ready(out_ready),
    .out_wb(out_wb_h), .out_m(out_m_h), .out_ex(out_ex_h), .out_npc(out_npc_h),
    .out_rdata1(out_rdata1_h), .out_rdata2(out_rdata2_h), .out_sext(out_sext_h),
    .out_rt(out_rt_h), .out_rd(out_rd_h), .occ(occ_h)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  id_ex_bundle_t q[$];    // accepted, not yet consumed, oldest first
  id_ex_bundle_t shown;   // what the main register should hold

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic id_ex_bundle_t rand_bundle();
    id_ex_bundle_t b;
    b.wb     = 2'($urandom);
    b.m      = 3'($urandom);
    b.ex     = 4'($urandom);
    b.npc    = $urandom;
    b.rdata1 = $urandom;
    b.rdata2 = $urandom;
    b.sext   = $urandom;
    b.rt     = 5'($urandom);
    b.rd     = 5'($urandom);
    return b;
  endfunction

  task automatic check_outputs();
    logic [1:0] e_occ;
    logic       e_vld;
    logic [8:0] e_ctl_z;
    e_occ   = 2'(q.size());
    e_vld   = (q.size() > 0);
    e_ctl_z = e_vld ? {shown.wb, shown.m, shown.ex} : 9'd0;
    chk("in_ready_z",  in_ready_z,  (q.size() < 2));
    chk("in_ready_h",  in_ready_h,  (q.size() < 2));
    chk("out_valid_z", out_valid_z, e_vld);
    chk("out_valid_h", out_valid_h, e_vld);
    chk("occ_z", occ_z, e_occ);
    chk("occ_h", occ_h, e_occ);
    chk("data_z", obz[137:0], shown[137:0]);
    chk("data_h", obh[137:0], shown[137:0]);
    chk("ctl_z", {out_wb_z, out_m_z, out_ex_z}, e_ctl_z);
    chk("ctl_h", {out_wb_h, out_m_h, out_ex_h}, {shown.wb, shown.m, shown.ex});
  endtask

  // Advance the scoreboard across the coming rising edge using current inputs.
  task automatic model_step();
    logic acc, cons;
    if (!rst_n) begin
      q.delete();
      shown = '0;
      return;
    end
    acc  = in_valid && (q.size() < 2);
    cons = (q.size() > 0) && out_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (cons) void'(q.pop_front());
      if (acc)  q.push_back(ib);
    end
    if (q.size() > 0) shown = q[0];
  endtask

  task automatic cyc();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    shown = '0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ib = '0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      ib = rand_bundle();
      in_valid = 1'($urandom); flush = 1'($urandom); out_ready = 1'($urandom);
      cyc();
    end
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cyc();

    // Streaming npc 0x04, 0x08, 0x0C
    for (int k = 1; k <= 3; k++) begin
      ib = rand_bundle(); ib.npc = 32'(4*k); in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    cyc(); cyc();

    // Stall: A then B with out_ready=0, C offered while full
    out_ready = 1'b0;
    ib = rand_bundle(); ib.rdata1 = 32'hAAAA; in_valid = 1'b1; cyc();
    ib = rand_bundle(); ib.rdata1 = 32'hBBBB; cyc();
    ib = rand_bundle(); ib.rdata1 = 32'hCCCC;
    cyc(); cyc(); cyc();
    in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc(); cyc();

    // Flush while FULL with an input presented in the same cycle
    out_ready = 1'b0;
    ib = rand_bundle(); ib.wb = 2'b11; in_valid = 1'b1; cyc();
    ib = rand_bundle(); ib.wb = 2'b10; cyc();
    ib = rand_bundle(); ib.wb = 2'b01; flush = 1'b1; cyc();
    flush = 1'b0; in_valid = 1'b0; cyc();
    out_ready = 1'b1; cyc(); cyc();

    // Bubble masking: wb=11 then starve
    ib = rand_bundle(); ib.wb = 2'b11; in_valid = 1'b1; cyc();
    in_valid = 1'b0;
    cyc(); cyc(); cyc();

    // Async reset between edges while FULL
    out_ready = 1'b0;
    ib = rand_bundle(); in_valid = 1'b1; cyc();
    ib = rand_bundle(); cyc();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete(); shown = '0;
    check_outputs();
    cyc();
    rst_n = 1'b1;
    ib = rand_bundle(); in_valid = 1'b1; out_ready = 1'b1; cyc();
    in_valid = 1'b0; cyc(); cyc();

    // Random traffic with occasional flush
    for (int i = 0; i < 60; i++) begin
      ib = rand_bundle();
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      cyc();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
